// File: rtl/bkm_input_precision_stage_if.sv
// rtl/bkm_input_precision_stage_if.sv - operand handshake and status bundle for the BKM input precision stage
interface bkm_input_precision_stage_if #(
  parameter int W     = 16,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_format;
  logic             in_round;
  logic [W-1:0]     in_e_x;
  logic [W-1:0]     in_e_y;
  logic [W-1:0]     in_l_x;
  logic [W-1:0]     in_l_y;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_format;
  logic [W-1:0]     out_e_x;
  logic [W-1:0]     out_e_y;
  logic [W-1:0]     out_l_x;
  logic [W-1:0]     out_l_y;
  logic [3:0]       out_sat;
  logic             sat_sticky;
  logic             sat_clr;
  logic [CNT_W-1:0] xfer_cnt;

  // Producer / consumer / status side, as seen from outside the stage
  modport master (
    output in_valid, in_format, in_round, in_e_x, in_e_y, in_l_x, in_l_y,
    output out_ready, sat_clr,
    input  in_ready, out_valid, out_format, out_e_x, out_e_y, out_l_x, out_l_y,
    input  out_sat, sat_sticky, xfer_cnt
  );

  // The precision stage itself
  modport slave (
    input  in_valid, in_format, in_round, in_e_x, in_e_y, in_l_x, in_l_y,
    input  out_ready, sat_clr,
    output in_ready, out_valid, out_format, out_e_x, out_e_y, out_l_x, out_l_y,
    output out_sat, sat_sticky, xfer_cnt
  );
endinterface

// File: rtl/bkm_input_precision_stage.sv
// rtl/bkm_input_precision_stage.sv - precision reduction with 2-entry skid buffer ahead of the BKM core
module bkm_input_precision_stage #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  bkm_input_precision_stage_if.slave   bus
);

  // Number of discarded low bits for each format: P = W, W/2, W/4, W/8
  localparam int D1 = W / 2;
  localparam int D2 = W - (W / 4);
  localparam int D3 = W - (W / 8);
  // Buffered payload: {format, sat[3:0], e_x, e_y, l_x, l_y}
  localparam int BW = 6 + 4 * W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  // Returns {saturated, reduced value} for one operand
  function automatic logic [W:0] reduce(input logic [W-1:0] x, input logic [1:0] fmt, input logic rnd);
    logic [W-1:0] mask;
    logic [W-1:0] half;
    logic [W-1:0] sum;
    logic [W-1:0] sat_val;
    logic         ovf;
    case (fmt)
      2'b01:   begin mask = {W{1'b1}} << D1; half = W'(1) << (D1 - 1); end
      2'b10:   begin mask = {W{1'b1}} << D2; half = W'(1) << (D2 - 1); end
      2'b11:   begin mask = {W{1'b1}} << D3; half = W'(1) << (D3 - 1); end
      default: begin mask = {W{1'b1}};       half = '0;                 end
    endcase
    // A non-negative x plus half never exceeds W bits unsigned, so a set
    // sign bit is exactly the signed overflow; negative x cannot overflow.
    sum     = rnd ? (x + half) : x;
    ovf     = rnd & ~x[W-1] & sum[W-1];
    sat_val = mask & {1'b0, {(W-1){1'b1}}};
    return {ovf, (ovf ? sat_val : (sum & mask))};
  endfunction

  state_t           r_state;
  state_t           w_next_state;
  logic             r_in_ready;
  logic [BW-1:0]    r_out_data;
  logic [BW-1:0]    r_skid_data;
  logic             r_sat_sticky;
  logic [CNT_W-1:0] r_xfer_cnt;

  logic [W:0]       w_red_ex;
  logic [W:0]       w_red_ey;
  logic [W:0]       w_red_lx;
  logic [W:0]       w_red_ly;
  logic [3:0]       w_sat;
  logic [BW-1:0]    w_in_data;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_drain;
  logic             w_load_out;
  logic             w_load_skid;
  logic             w_out_from_skid;

  assign w_red_ex  = reduce(bus.in_e_x, bus.in_format, bus.in_round);
  assign w_red_ey  = reduce(bus.in_e_y, bus.in_format, bus.in_round);
  assign w_red_lx  = reduce(bus.in_l_x, bus.in_format, bus.in_round);
  assign w_red_ly  = reduce(bus.in_l_y, bus.in_format, bus.in_round);
  assign w_sat     = {w_red_ly[W], w_red_lx[W], w_red_ey[W], w_red_ex[W]};
  assign w_in_data = {bus.in_format, w_sat, w_red_ex[W-1:0], w_red_ey[W-1:0],
                      w_red_lx[W-1:0], w_red_ly[W-1:0]};

  assign w_out_valid = (r_state != S_EMPTY);
  assign w_accept    = bus.in_valid & r_in_ready;
  assign w_drain     = w_out_valid & bus.out_ready;

  // Buffer occupancy state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_next_state;
  end

  // Occupancy transitions from accept/drain
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_next_state = S_ONE;
      S_ONE: begin
        if (w_accept && !w_drain)      w_next_state = S_TWO;
        else if (!w_accept && w_drain) w_next_state = S_EMPTY;
      end
      S_TWO:   if (w_drain) w_next_state = S_ONE;
      default: w_next_state = S_EMPTY;
    endcase
  end

  // Data-path steering for each occupancy state
  always_comb begin
    w_load_out      = 1'b0;
    w_load_skid     = 1'b0;
    w_out_from_skid = 1'b0;
    case (r_state)
      S_EMPTY: w_load_out = w_accept;
      S_ONE: begin
        w_load_out  = w_accept & w_drain;
        w_load_skid = w_accept & ~w_drain;
      end
      S_TWO:   w_out_from_skid = w_drain;
      default: w_load_out = 1'b0;
    endcase
  end

  // in_ready is registered: low only while both entries are occupied
  always_ff @(posedge clk) begin
    if (rst) r_in_ready <= 1'b1;
    else     r_in_ready <= (w_next_state != S_TWO);
  end

  // Output register and skid entry; the output register holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_out)           r_out_data <= w_in_data;
      else if (w_out_from_skid) r_out_data <= r_skid_data;
      if (w_load_skid)          r_skid_data <= w_in_data;
    end
  end

  // Sticky saturation flag; a new saturating accept beats a clear
  always_ff @(posedge clk) begin
    if (rst)                        r_sat_sticky <= 1'b0;
    else if (w_accept && |w_sat)    r_sat_sticky <= 1'b1;
    else if (bus.sat_clr)           r_sat_sticky <= 1'b0;
  end

  // Free-running count of output transfers, wrapping naturally
  always_ff @(posedge clk) begin
    if (rst)          r_xfer_cnt <= '0;
    else if (w_drain) r_xfer_cnt <= r_xfer_cnt + 1'b1;
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_format = r_out_data[BW-1 -: 2];
  assign bus.out_sat    = r_out_data[BW-3 -: 4];
  assign bus.out_e_x    = r_out_data[4*W-1 -: W];
  assign bus.out_e_y    = r_out_data[3*W-1 -: W];
  assign bus.out_l_x    = r_out_data[2*W-1 -: W];
  assign bus.out_l_y    = r_out_data[W-1 -: W];
  assign bus.sat_sticky = r_sat_sticky;
  assign bus.xfer_cnt   = r_xfer_cnt;

endmodule

// File: tb/tb_bkm_input_precision_stage.sv
// tb/tb_bkm_input_precision_stage.sv - self-checking bench for bkm_input_precision_stage
module tb_bkm_input_precision_stage;
  localparam int W     = 8;
  localparam int CNT_W = 5;

  typedef struct {
    logic [1:0]   fmt;
    logic [3:0]   sat;
    logic [W-1:0] ex;
    logic [W-1:0] ey;
    logic [W-1:0] lx;
    logic [W-1:0] ly;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  item_t        q[$];
  logic         exp_sticky = 1'b0;
  int           exp_cnt = 0;
  logic [W-1:0] drained_ex[$];

  always #5 clk = ~clk;

  bkm_input_precision_stage_if #(.W(W), .CNT_W(CNT_W)) bus ();

  bkm_input_precision_stage #(.W(W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reduce to a multiple of 2^D by floor; rounding adds half a step first;
  // anything above the largest positive value clamps to the largest multiple.
  function automatic void ref_reduce(input logic [W-1:0] x, input logic [1:0] f, input logic r,
                                     output logic [W-1:0] y, output logic s);
    int d, v, res, maxv;
    logic [31:0] resv;
    d    = W - (W >> f);
    v    = int'($signed(x));
    maxv = (1 << (W - 1)) - 1;
    res  = (r && d > 0) ? v + (1 << (d - 1)) : v;
    res  = (res >>> d) << d;
    s    = 1'b0;
    if (res > maxv) begin
      s   = 1'b1;
      res = (maxv >>> d) << d;
    end
    resv = res;
    y    = resv[W-1:0];
  endfunction

  function automatic item_t ref_item();
    item_t it;
    logic s0, s1, s2, s3;
    it.fmt = bus.in_format;
    ref_reduce(bus.in_e_x, bus.in_format, bus.in_round, it.ex, s0);
    ref_reduce(bus.in_e_y, bus.in_format, bus.in_round, it.ey, s1);
    ref_reduce(bus.in_l_x, bus.in_format, bus.in_round, it.lx, s2);
    ref_reduce(bus.in_l_y, bus.in_format, bus.in_round, it.ly, s3);
    it.sat = {s3, s2, s1, s0};
    return it;
  endfunction

  task automatic set_in(input logic v, input logic [1:0] f, input logic r,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] d);
    bus.in_valid  = v;
    bus.in_format = f;
    bus.in_round  = r;
    bus.in_e_x    = a;
    bus.in_e_y    = b;
    bus.in_l_x    = c;
    bus.in_l_y    = d;
  endtask

  // One clock: decide accept/drain from the queue model, clock, update model
  task automatic tick(input logic ordy, input logic clr);
    item_t it;
    logic acc, drn;
    bus.out_ready = ordy;
    bus.sat_clr   = clr;
    acc = !rst && bus.in_valid && (q.size() < 2);
    drn = !rst && (q.size() > 0) && ordy;
    if (acc) it = ref_item();
    if (drn) drained_ex.push_back(bus.out_e_x);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      exp_sticky = 1'b0;
      exp_cnt    = 0;
    end else begin
      if (drn) begin
        q.delete(0);
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      end
      if (acc) q.push_back(it);
      if (acc && it.sat != 4'd0) exp_sticky = 1'b1;
      else if (clr)              exp_sticky = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_in(1'b0, 2'b00, 1'b0, '0, '0, '0, '0);
    apply_reset();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_handshake got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    checks++;
    if ({bus.out_format, bus.out_sat, bus.out_e_x, bus.out_e_y, bus.out_l_x, bus.out_l_y} !== '0) begin
      failures++;
      $display("FAIL reset_data got fmt=%h sat=%h ex=%h ey=%h lx=%h ly=%h want all 0",
               bus.out_format, bus.out_sat, bus.out_e_x, bus.out_e_y, bus.out_l_x, bus.out_l_y);
    end
    checks++;
    if (bus.sat_sticky !== 1'b0 || bus.xfer_cnt !== '0) begin
      failures++;
      $display("FAIL reset_status got sticky=%b cnt=%0d want 0/0", bus.sat_sticky, bus.xfer_cnt);
    end
  endtask

  task automatic test_truncate();
    set_in(1'b1, 2'b01, 1'b0, 8'h37, W'($urandom), W'($urandom), W'($urandom));
    tick(1'b1, 1'b0);
    set_in(1'b0, 2'b00, 1'b0, '0, '0, '0, '0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_e_x !== 8'h30 || bus.out_sat !== 4'd0) begin
      failures++;
      $display("FAIL truncate_37 got valid=%b ex=%h sat=%b want 1/30/0000", bus.out_valid, bus.out_e_x, bus.out_sat);
    end
    tick(1'b1, 1'b0);
  endtask

  task automatic test_round_sat();
    set_in(1'b1, 2'b01, 1'b1, 8'h39, 8'h7C, 8'hE5, 8'h80);
    tick(1'b1, 1'b0);
    set_in(1'b0, 2'b00, 1'b0, '0, '0, '0, '0);
    checks++;
    if ({bus.out_e_x, bus.out_e_y, bus.out_l_x, bus.out_l_y} !== 32'h4070E080) begin
      failures++;
      $display("FAIL round_values got %h %h %h %h want 40 70 e0 80", bus.out_e_x, bus.out_e_y, bus.out_l_x, bus.out_l_y);
    end
    checks++;
    if (bus.out_sat !== 4'b0010 || bus.sat_sticky !== 1'b1) begin
      failures++;
      $display("FAIL round_sat got sat=%b sticky=%b want 0010/1", bus.out_sat, bus.sat_sticky);
    end
    set_in(1'b1, 2'b01, 1'b1, 8'h7C, 8'h00, 8'h00, 8'h00);
    tick(1'b1, 1'b1);
    set_in(1'b0, 2'b00, 1'b0, '0, '0, '0, '0);
    checks++;
    if (bus.sat_sticky !== 1'b1) begin
      failures++;
      $display("FAIL sticky_set_wins got %b want 1", bus.sat_sticky);
    end
    tick(1'b1, 1'b1);
    checks++;
    if (bus.sat_sticky !== 1'b0) begin
      failures++;
      $display("FAIL sticky_clear got %b want 0", bus.sat_sticky);
    end
    tick(1'b1, 1'b0);
  endtask

  task automatic test_formats();
    // {fmt, rnd, ex, ey, lx, ly, want ex, ey, lx, ly, want sat}
    logic [1:0]   tf[5] = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b01};
    logic         tr[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0]  ti[5] = '{32'hE5DF0000, 32'h40A0007F, 32'h7F805AC3, 32'h7F805AC3, 32'hE5FF807F};
    logic [31:0]  to[5] = '{32'h00C00000, 32'h00800000, 32'h7F805AC3, 32'h7F805AC3, 32'hE0F08070};
    logic [3:0]   ts[5] = '{4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000};
    logic [31:0]  v;
    for (int i = 0; i < 5; i++) begin
      v = ti[i];
      set_in(1'b1, tf[i], tr[i], v[31:24], v[23:16], v[15:8], v[7:0]);
      tick(1'b1, 1'b0);
      checks++;
      if ({bus.out_e_x, bus.out_e_y, bus.out_l_x, bus.out_l_y} !== to[i] || bus.out_sat !== ts[i]
          || bus.out_format !== tf[i]) begin
        failures++;
        $display("FAIL format_case%0d got %h%h%h%h sat=%b fmt=%b want %h sat=%b fmt=%b", i,
                 bus.out_e_x, bus.out_e_y, bus.out_l_x, bus.out_l_y, bus.out_sat, bus.out_format,
                 to[i], ts[i], tf[i]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      v = $urandom;
      set_in(1'b1, 2'b00, 1'($urandom), v[31:24], v[23:16], v[15:8], v[7:0]);
      tick(1'b1, 1'b0);
      checks++;
      if ({bus.out_e_x, bus.out_e_y, bus.out_l_x, bus.out_l_y} !== v || bus.out_sat !== 4'd0) begin
        failures++;
        $display("FAIL format00_pass%0d got %h%h%h%h sat=%b want %h sat=0000", i,
                 bus.out_e_x, bus.out_e_y, bus.out_l_x, bus.out_l_y, bus.out_sat, v);
      end
    end
    set_in(1'b0, 2'b00, 1'b0, '0, '0, '0, '0);
    tick(1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    drained_ex.delete();
    set_in(1'b1, 2'b00, 1'b0, 8'h11, 8'h01, 8'h02, 8'h03);
    tick(1'b0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_after_a got valid=%b ready=%b want 1/1", bus.out_valid, bus.in_ready);
    end
    set_in(1'b1, 2'b00, 1'b0, 8'h22, 8'h04, 8'h05, 8'h06);
    tick(1'b0, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_e_x !== 8'h11) begin
      failures++;
      $display("FAIL bp_after_b got ready=%b ex=%h want 0/11", bus.in_ready, bus.out_e_x);
    end
    set_in(1'b1, 2'b00, 1'b0, 8'h33, 8'h07, 8'h08, 8'h09);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_e_x !== 8'h11 || bus.out_e_y !== 8'h01) begin
        failures++;
        $display("FAIL bp_stall%0d got ready=%b valid=%b ex=%h ey=%h want 0/1/11/01", i,
                 bus.in_ready, bus.out_valid, bus.out_e_x, bus.out_e_y);
      end
    end
    tick(1'b1, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_e_x !== 8'h22) begin
      failures++;
      $display("FAIL bp_release got ready=%b ex=%h want 1/22", bus.in_ready, bus.out_e_x);
    end
    tick(1'b1, 1'b0);
    set_in(1'b0, 2'b00, 1'b0, '0, '0, '0, '0);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_e_x !== 8'h33 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_c_loaded got ready=%b valid=%b ex=%h want 1/1/33", bus.in_ready, bus.out_valid, bus.out_e_x);
    end
    tick(1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0 || drained_ex.size() != 3) begin
      failures++;
      $display("FAIL bp_drain_count got valid=%b drained=%0d want 0/3", bus.out_valid, drained_ex.size());
    end else begin
      checks++;
      if (drained_ex[0] !== 8'h11 || drained_ex[1] !== 8'h22 || drained_ex[2] !== 8'h33) begin
        failures++;
        $display("FAIL bp_order got %h %h %h want 11 22 33", drained_ex[0], drained_ex[1], drained_ex[2]);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    set_in(1'b1, 2'($urandom), 1'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    tick(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 2'($urandom), 1'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      tick(1'b1, 1'b0);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || q.size() != 1) begin
        failures++;
        $display("FAIL b2b_flow%0d got ready=%b valid=%b want 1/1", i, bus.in_ready, bus.out_valid);
      end else begin
        checks++;
        if ({bus.out_format, bus.out_sat, bus.out_e_x, bus.out_e_y, bus.out_l_x, bus.out_l_y} !==
            {q[0].fmt, q[0].sat, q[0].ex, q[0].ey, q[0].lx, q[0].ly}) begin
          failures++;
          $display("FAIL b2b_data%0d got %b %b %h %h %h %h want %b %b %h %h %h %h", i,
                   bus.out_format, bus.out_sat, bus.out_e_x, bus.out_e_y, bus.out_l_x, bus.out_l_y,
                   q[0].fmt, q[0].sat, q[0].ex, q[0].ey, q[0].lx, q[0].ly);
        end
      end
    end
    checks++;
    if (bus.xfer_cnt !== 5'd20) begin
      failures++;
      $display("FAIL b2b_xfer_cnt got %0d want 20", bus.xfer_cnt);
    end
    set_in(1'b0, 2'b00, 1'b0, '0, '0, '0, '0);
    tick(1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      set_in(($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom),
             W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      tick(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
      checks++;
      if (bus.in_ready !== (q.size() < 2) || bus.out_valid !== (q.size() > 0)) begin
        failures++;
        $display("FAIL rnd_handshake%0d got ready=%b valid=%b want %b/%b", i,
                 bus.in_ready, bus.out_valid, (q.size() < 2), (q.size() > 0));
      end
      if (q.size() > 0) begin
        checks++;
        if ({bus.out_format, bus.out_sat, bus.out_e_x, bus.out_e_y, bus.out_l_x, bus.out_l_y} !==
            {q[0].fmt, q[0].sat, q[0].ex, q[0].ey, q[0].lx, q[0].ly}) begin
          failures++;
          $display("FAIL rnd_data%0d got %b %b %h %h %h %h want %b %b %h %h %h %h", i,
                   bus.out_format, bus.out_sat, bus.out_e_x, bus.out_e_y, bus.out_l_x, bus.out_l_y,
                   q[0].fmt, q[0].sat, q[0].ex, q[0].ey, q[0].lx, q[0].ly);
        end
      end
      checks++;
      if (bus.sat_sticky !== exp_sticky || bus.xfer_cnt !== CNT_W'(exp_cnt)) begin
        failures++;
        $display("FAIL rnd_status%0d got sticky=%b cnt=%0d want %b/%0d", i,
                 bus.sat_sticky, bus.xfer_cnt, exp_sticky, exp_cnt);
      end
    end
    set_in(1'b0, 2'b00, 1'b0, '0, '0, '0, '0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
  endtask

  task automatic test_reset_in_two();
    set_in(1'b1, 2'b01, 1'b1, 8'h7C, 8'h10, 8'h20, 8'h30);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.sat_sticky !== 1'b1) begin
      failures++;
      $display("FAIL rst2_fill got ready=%b sticky=%b want 0/1", bus.in_ready, bus.sat_sticky);
    end
    apply_reset();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.xfer_cnt !== '0 || bus.sat_sticky !== 1'b0) begin
      failures++;
      $display("FAIL rst2_state got valid=%b ready=%b cnt=%0d sticky=%b want 0/1/0/0",
               bus.out_valid, bus.in_ready, bus.xfer_cnt, bus.sat_sticky);
    end
    set_in(1'b1, 2'b00, 1'b0, 8'h5C, 8'h6D, 8'h7E, 8'h8F);
    tick(1'b0, 1'b0);
    set_in(1'b0, 2'b00, 1'b0, '0, '0, '0, '0);
    checks++;
    if (bus.out_valid !== 1'b1 || {bus.out_e_x, bus.out_e_y, bus.out_l_x, bus.out_l_y} !== 32'h5C6D7E8F) begin
      failures++;
      $display("FAIL rst2_first_out got valid=%b data=%h%h%h%h want 1/5c6d7e8f",
               bus.out_valid, bus.out_e_x, bus.out_e_y, bus.out_l_x, bus.out_l_y);
    end
    tick(1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.xfer_cnt !== 5'd1) begin
      failures++;
      $display("FAIL rst2_drain got valid=%b cnt=%0d want 0/1", bus.out_valid, bus.xfer_cnt);
    end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    bus.sat_clr   = 1'b0;
    test_reset();
    test_truncate();
    test_round_sat();
    test_formats();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_in_two();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
